// File: rtl/lock_keypad_conditioner_if.sv
// Keypad pin bundle between the user pins and the lock FSM: raw button/digit in, conditioned strobes out.
// glitch_flag exists only when KEYPAD_GLITCH_FLAG_EN is defined.
interface lock_keypad_conditioner_if;
  logic       btn_enter_raw;
  logic [3:0] digit_raw;
  logic       enter_pulse;
  logic [3:0] digit_out;
  logic       digit_valid;
  logic       btn_level;
`ifdef KEYPAD_GLITCH_FLAG_EN
  logic       glitch_flag;
`endif

  // master is the pin side (drives raw inputs), slave is the conditioner itself
  modport master (
    output btn_enter_raw,
    output digit_raw,
    input  enter_pulse,
    input  digit_out,
    input  digit_valid,
    input  btn_level
`ifdef KEYPAD_GLITCH_FLAG_EN
    , input glitch_flag
`endif
  );

  modport slave (
    input  btn_enter_raw,
    input  digit_raw,
    output enter_pulse,
    output digit_out,
    output digit_valid,
    output btn_level
`ifdef KEYPAD_GLITCH_FLAG_EN
    , output glitch_flag
`endif
  );
endinterface

// File: rtl/lock_keypad_conditioner.sv
// Synchronizes and debounces the lock's enter button, emitting one pulse plus the captured digit per press.
// Define KEYPAD_GLITCH_FLAG_EN to add glitch_flag, pulsing on every rejected press or release bounce.
module lock_keypad_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  lock_keypad_conditioner_if.slave  kp
);
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_RELEASE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             btn_meta, btn_s;
  logic [3:0]       dig_meta, dig_s;
  logic             accept;
  logic             enter_pulse_q, digit_valid_q, btn_level_q;
  logic [3:0]       digit_out_q;

  // Two-flop synchronizers; the digit bus is only synchronized, the user sets it before pressing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      dig_meta <= '0;
      dig_s    <= '0;
    end else begin
      btn_meta <= kp.btn_enter_raw;
      btn_s    <= btn_meta;
      dig_meta <= kp.digit_raw;
      dig_s    <= dig_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // cnt_next defaults to zero so the counter restarts on every state entry and never wraps
  always_comb begin
    state_next = state;
    cnt_next   = '0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) state_next = DB_PRESS;
      end
      DB_PRESS: begin
        if (!btn_s) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next = PRESSED;
          accept     = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) state_next = DB_RELEASE;
      end
      DB_RELEASE: begin
        if (btn_s) begin
          state_next = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the transition being taken on this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enter_pulse_q <= 1'b0;
      digit_out_q   <= '0;
      digit_valid_q <= 1'b0;
      btn_level_q   <= 1'b0;
    end else begin
      enter_pulse_q <= accept;
      btn_level_q   <= (state_next == PRESSED) || (state_next == DB_RELEASE);
      if (accept) begin
        digit_out_q   <= dig_s;
        digit_valid_q <= 1'b1;
      end
    end
  end

  assign kp.enter_pulse = enter_pulse_q;
  assign kp.digit_out   = digit_out_q;
  assign kp.digit_valid = digit_valid_q;
  assign kp.btn_level   = btn_level_q;

`ifdef KEYPAD_GLITCH_FLAG_EN
  logic glitch_q;

  // A press abort or a release bounce is exactly a debounce state seeing the opposite level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_q <= 1'b0;
    end else begin
      glitch_q <= ((state == DB_PRESS) && !btn_s) || ((state == DB_RELEASE) && btn_s);
    end
  end

  assign kp.glitch_flag = glitch_q;
`endif
endmodule

// File: tb/tb_lock_keypad_conditioner.sv
// Self-checking bench for lock_keypad_conditioner with DEBOUNCE_CYCLES=4 against a run-length reference model.
module tb_lock_keypad_conditioner;
  localparam int D    = 4;
  localparam int HIST = 8192;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;

  lock_keypad_conditioner_if kp ();

  lock_keypad_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp)
  );

  always #5 clk = ~clk;

  // Reference model: raw samples are logged per edge since reset; the debounced level flips
  // once the last D+1 synchronized samples all show the opposite level.
  bit         raw_at [HIST];
  logic [3:0] dig_at [HIST];
  int         k_idx;
  bit         m_level;
  bit         m_pulse;
  logic [3:0] m_digit;
  bit         m_valid;
`ifdef KEYPAD_GLITCH_FLAG_EN
  bit         m_glitch;
`endif

  function automatic bit s_at(int j);
    if (j < 2 || j - 2 >= HIST) return 1'b0;
    return raw_at[j-2];
  endfunction

  function automatic logic [3:0] dig_s_at(int j);
    if (j < 2 || j - 2 >= HIST) return 4'h0;
    return dig_at[j-2];
  endfunction

  function automatic bit stable_run(int k, bit v);
    for (int i = 0; i <= D; i++) if (s_at(k - i) != v) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_idx   <= 0;
      m_level <= 1'b0;
      m_pulse <= 1'b0;
      m_digit <= 4'h0;
      m_valid <= 1'b0;
`ifdef KEYPAD_GLITCH_FLAG_EN
      m_glitch <= 1'b0;
`endif
    end else begin
      if (k_idx < HIST) begin
        raw_at[k_idx] <= kp.btn_enter_raw;
        dig_at[k_idx] <= kp.digit_raw;
      end
      k_idx   <= k_idx + 1;
      m_pulse <= 1'b0;
      if (stable_run(k_idx, !m_level)) begin
        m_level <= !m_level;
        if (!m_level) begin
          m_pulse <= 1'b1;
          m_digit <= dig_s_at(k_idx);
          m_valid <= 1'b1;
        end
      end
`ifdef KEYPAD_GLITCH_FLAG_EN
      m_glitch <= (s_at(k_idx - 1) != s_at(k_idx)) && (s_at(k_idx) == m_level);
`endif
    end
  end

  function automatic logic [6:0] exp_bus();
    return {m_pulse, m_digit, m_valid, m_level};
  endfunction

  function automatic logic [6:0] obs_bus();
    return {kp.enter_pulse, kp.digit_out, kp.digit_valid, kp.btn_level};
  endfunction

  task automatic test_reset();
    kp.btn_enter_raw = 1'b0;
    kp.digit_raw     = 4'h0;
    rst_n            = 1'b0;
    #17;
    checks++;
    if (obs_bus() !== 7'd0) $display("[TB] FAIL reset_outputs: got %b want %b", obs_bus(), 7'd0);
    else passed++;
`ifdef KEYPAD_GLITCH_FLAG_EN
    checks++;
    if (kp.glitch_flag !== 1'b0) $display("[TB] FAIL reset_glitch: got %b want 0", kp.glitch_flag);
    else passed++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs_bus() !== exp_bus()) $display("[TB] FAIL reset_idle cyc %0d: got %b want %b", i, obs_bus(), exp_bus());
      else passed++;
    end
  endtask

  task automatic test_clean_press();
    int   pulses   = 0;
    int   pulse_at = -1;
    logic lvl19    = 1'b0;
    kp.digit_raw = 4'h5;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      kp.btn_enter_raw = (i < 20);
      @(negedge clk);
      checks++;
      if (obs_bus() !== exp_bus()) $display("[TB] FAIL clean_press cyc %0d: got %b want %b", i, obs_bus(), exp_bus());
      else passed++;
      if (kp.enter_pulse) begin
        pulses++;
        if (pulse_at < 0) pulse_at = i;
      end
      if (i == 19) lvl19 = kp.btn_level;
    end
    checks++;
    if (pulse_at != D + 2) $display("[TB] FAIL clean_latency: got %0d want %0d", pulse_at, D + 2);
    else passed++;
    checks++;
    if (pulses != 1) $display("[TB] FAIL clean_pulses: got %0d want 1", pulses);
    else passed++;
    checks++;
    if (kp.digit_out !== 4'h5 || kp.digit_valid !== 1'b1 || lvl19 !== 1'b1)
      $display("[TB] FAIL clean_digit: got digit %h valid %b level %b want 5 1 1", kp.digit_out, kp.digit_valid, lvl19);
    else passed++;
  endtask

  task automatic test_short_glitch();
    int pulses   = 0;
    int glitches = 0;
    kp.digit_raw = 4'hA;
    for (int i = 0; i < 14; i++) begin
      kp.btn_enter_raw = (i < 2);
      @(negedge clk);
      checks++;
      if (obs_bus() !== exp_bus()) $display("[TB] FAIL glitch cyc %0d: got %b want %b", i, obs_bus(), exp_bus());
      else passed++;
      if (kp.enter_pulse) pulses++;
`ifdef KEYPAD_GLITCH_FLAG_EN
      if (kp.glitch_flag) glitches++;
      checks++;
      if (kp.glitch_flag !== m_glitch) $display("[TB] FAIL glitch_flag cyc %0d: got %b want %b", i, kp.glitch_flag, m_glitch);
      else passed++;
`endif
    end
    checks++;
    if (pulses != 0 || kp.digit_out !== 4'h5 || kp.digit_valid !== 1'b1)
      $display("[TB] FAIL glitch_no_pulse: got pulses %0d digit %h valid %b want 0 5 1", pulses, kp.digit_out, kp.digit_valid);
    else passed++;
`ifdef KEYPAD_GLITCH_FLAG_EN
    checks++;
    if (glitches != 1) $display("[TB] FAIL glitch_count: got %0d want 1", glitches);
    else passed++;
`endif
  endtask

  task automatic test_bounce();
    logic [0:29] pat     = 30'b10101_1111111111_010_000000000000;
    int          pulses  = 0;
    int          fall_at = -1;
    kp.digit_raw = 4'h7;
    for (int i = 0; i < 30; i++) begin
      kp.btn_enter_raw = pat[i];
      @(negedge clk);
      checks++;
      if (obs_bus() !== exp_bus()) $display("[TB] FAIL bounce cyc %0d: got %b want %b", i, obs_bus(), exp_bus());
      else passed++;
`ifdef KEYPAD_GLITCH_FLAG_EN
      checks++;
      if (kp.glitch_flag !== m_glitch) $display("[TB] FAIL bounce_flag cyc %0d: got %b want %b", i, kp.glitch_flag, m_glitch);
      else passed++;
`endif
      if (kp.enter_pulse) pulses++;
      if (i > 15 && !kp.btn_level && fall_at < 0) fall_at = i;
    end
    checks++;
    if (pulses != 1) $display("[TB] FAIL bounce_pulses: got %0d want 1", pulses);
    else passed++;
    // Stable low is first sampled at cycle 17, synchronized two edges later, then D more edges
    checks++;
    if (fall_at != 17 + 2 + D) $display("[TB] FAIL bounce_release: got %0d want %0d", fall_at, 17 + 2 + D);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int         pulses = 0;
    logic [3:0] first_dig  = 4'h0;
    logic [3:0] mid_dig    = 4'h0;
    logic [3:0] second_dig = 4'h0;
    for (int i = 0; i < 48; i++) begin
      kp.btn_enter_raw = (i >= 2 && i < 12) || (i >= 28 && i < 38);
      kp.digit_raw     = (i < 20) ? 4'h3 : 4'h9;
      @(negedge clk);
      checks++;
      if (obs_bus() !== exp_bus()) $display("[TB] FAIL b2b cyc %0d: got %b want %b", i, obs_bus(), exp_bus());
      else passed++;
      if (kp.enter_pulse) begin
        pulses++;
        if (pulses == 1) first_dig = kp.digit_out;
        else second_dig = kp.digit_out;
      end
      if (i == 27) mid_dig = kp.digit_out;
    end
    checks++;
    if (pulses != 2) $display("[TB] FAIL b2b_pulses: got %0d want 2", pulses);
    else passed++;
    checks++;
    if ({first_dig, mid_dig, second_dig} !== 12'h339)
      $display("[TB] FAIL b2b_digits: got %h %h %h want 3 3 9", first_dig, mid_dig, second_dig);
    else passed++;
  endtask

  task automatic test_long_hold();
    int early = 0;
    int total = 0;
    kp.digit_raw = 4'h2;
    for (int i = 0; i < 235; i++) begin
      kp.btn_enter_raw = (i < 200) || (i >= 212 && i < 222);
      @(negedge clk);
      checks++;
      if (obs_bus() !== exp_bus()) $display("[TB] FAIL long_hold cyc %0d: got %b want %b", i, obs_bus(), exp_bus());
      else passed++;
      if (kp.enter_pulse) begin
        total++;
        if (i < 210) early++;
      end
    end
    checks++;
    if (early != 1 || total != 2) $display("[TB] FAIL long_hold_pulses: got %0d/%0d want 1/2", early, total);
    else passed++;
  endtask

  task automatic test_mid_reset();
    int pulses   = 0;
    int pulse_at = -1;
    kp.digit_raw     = 4'hC;
    kp.btn_enter_raw = 1'b1;
    // Raw high is sampled at the first edge; DB_PRESS holds cnt=2 after the fifth
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs_bus() !== 7'd0) $display("[TB] FAIL midreset_clear: got %b want %b", obs_bus(), 7'd0);
    else passed++;
`ifdef KEYPAD_GLITCH_FLAG_EN
    checks++;
    if (kp.glitch_flag !== 1'b0) $display("[TB] FAIL midreset_glitch: got %b want 0", kp.glitch_flag);
    else passed++;
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      checks++;
      if (obs_bus() !== exp_bus()) $display("[TB] FAIL midreset cyc %0d: got %b want %b", i, obs_bus(), exp_bus());
      else passed++;
      if (kp.enter_pulse) begin
        pulses++;
        if (pulse_at < 0) pulse_at = i;
      end
    end
    checks++;
    if (pulse_at != D + 3 || pulses != 1)
      $display("[TB] FAIL midreset_pulse: got edge %0d count %0d want %0d 1", pulse_at, pulses, D + 3);
    else passed++;
    checks++;
    if (kp.digit_out !== 4'hC) $display("[TB] FAIL midreset_digit: got %h want c", kp.digit_out);
    else passed++;
    kp.btn_enter_raw = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random();
    int run_left = 0;
    for (int i = 0; i < 800; i++) begin
      if (run_left == 0) begin
        kp.btn_enter_raw = !kp.btn_enter_raw;
        run_left = $urandom_range(1, 9);
      end
      run_left--;
      if ($urandom_range(0, 3) == 0) kp.digit_raw = 4'($urandom);
      @(negedge clk);
      checks++;
      if (obs_bus() !== exp_bus()) $display("[TB] FAIL random cyc %0d: got %b want %b", i, obs_bus(), exp_bus());
      else passed++;
`ifdef KEYPAD_GLITCH_FLAG_EN
      checks++;
      if (kp.glitch_flag !== m_glitch) $display("[TB] FAIL random_flag cyc %0d: got %b want %b", i, kp.glitch_flag, m_glitch);
      else passed++;
`endif
    end
  endtask

  initial begin
    kp.btn_enter_raw = 1'b0;
    kp.digit_raw     = 4'h0;
    $display("[TB] start DEBOUNCE_CYCLES=%0d", D);
    test_reset();
    test_clean_press();
    test_short_glitch();
    test_bounce();
    test_back_to_back();
    test_long_hold();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
